// File: rtl/conway_pkg.sv
// conway_pkg: shared key codes, decoder states and pending-command encoding.
// ESC/CSI states exist only when CMD_ESC_FILTER_EN is defined.
package conway_pkg;
  localparam logic [7:0] KEY_INIT = 8'h30;
  localparam logic [7:0] KEY_STEP = 8'h31;
  localparam logic [7:0] KEY_RUN  = 8'h20;
  localparam logic [7:0] KEY_ESC  = 8'h1B;
  localparam logic [7:0] KEY_CSI  = 8'h5B;
  typedef enum logic [1:0] {
    BOOT,
    IDLE
`ifdef CMD_ESC_FILTER_EN
    ,
    ESC,
    CSI
`endif
  } dec_state_t;
  typedef enum logic [1:0] {NONE, INIT, STEP} pend_t;
endpackage

// File: rtl/conway_tick_timer.sv
// conway_tick_timer: auto-step interval counter; expires after INTERVAL enabled cycles.
// Clear dominates expiry so a stop/toggle in the expiry cycle suppresses the pulse.
module conway_tick_timer #(
  parameter int INTERVAL = 16,
  parameter int TIMER_W  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);
  logic [TIMER_W-1:0] r_cnt;
  assign o_expire = i_en && !i_clr && (r_cnt == TIMER_W'(INTERVAL - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clr || o_expire) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + TIMER_W'(1);
  end
endmodule

// File: rtl/conway_cmd_decoder.sv
// conway_cmd_decoder: turns received key bytes into init/step pulses, owns free-run and auto-step.
// Define CMD_ESC_FILTER_EN to swallow terminal escape sequences (ESC '[' ... final byte).
module conway_cmd_decoder
  import conway_pkg::*;
#(
  parameter int CLOCK_RATE = 48000000,
  parameter int TICK_RATE  = 5,
  parameter int TIMER_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       busy,
  output logic       cmd_init,
  output logic       cmd_step,
  output logic       step_auto,
  output logic       running
);
  localparam int INTERVAL = CLOCK_RATE / TICK_RATE;
  dec_state_t r_state, w_state_nx;
  pend_t      r_pend, w_pend_nx;
  logic       r_running, w_running_nx;
  logic       w_acc, w_clr, w_en, w_expire;
  assign rx_ready  = (r_pend == NONE);
  assign w_acc     = rx_valid && rx_ready;
  assign w_en      = r_running && !busy && (r_pend == NONE);
  assign cmd_init  = (r_pend == INIT) && !busy;
  assign cmd_step  = ((r_pend == STEP) && !busy) || w_expire;
  assign step_auto = w_expire;
  assign running   = r_running;
  conway_tick_timer #(.INTERVAL(INTERVAL), .TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_en),
    .i_clr    (w_clr),
    .o_expire (w_expire)
  );
  always_comb begin
    w_state_nx   = r_state;
    w_pend_nx    = busy ? r_pend : NONE;
    w_running_nx = r_running;
    w_clr        = 1'b0;
    if (w_acc) begin
      case (r_state)
        BOOT: begin
          w_pend_nx  = INIT;
          w_state_nx = IDLE;
        end
        IDLE: begin
          if (rx_data == KEY_INIT) w_pend_nx = INIT;
          else if (rx_data == KEY_STEP) begin
            if (r_running) begin
              w_running_nx = 1'b0;
              w_clr        = 1'b1;
            end else w_pend_nx = STEP;
          end else if (rx_data == KEY_RUN) begin
            w_running_nx = !r_running;
            w_clr        = 1'b1;
          end
`ifdef CMD_ESC_FILTER_EN
          else if (rx_data == KEY_ESC) w_state_nx = ESC;
`endif
        end
`ifdef CMD_ESC_FILTER_EN
        ESC: w_state_nx = (rx_data == KEY_CSI) ? CSI : IDLE;
        CSI: w_state_nx = (rx_data >= 8'h40 && rx_data <= 8'h7E) ? IDLE : CSI;
`endif
        default: w_state_nx = BOOT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= BOOT;
      r_pend    <= NONE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pend    <= w_pend_nx;
      r_running <= w_running_nx;
    end
  end
endmodule

// File: tb/tb_conway_cmd_decoder.sv
// tb_conway_cmd_decoder: directed vector table plus hand-written free-run/reset sequences.
// INTERVAL is 16 cycles (CLOCK_RATE=160, TICK_RATE=10).
module tb_conway_cmd_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       busy = 1'b0;
  logic       rx_ready, cmd_init, cmd_step, step_auto, running;
  int         n_chk = 0;
  int         n_err = 0;

  conway_cmd_decoder #(.CLOCK_RATE(160), .TICK_RATE(10), .TIMER_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .cmd_init  (cmd_init),
    .cmd_step  (cmd_step),
    .step_auto (step_auto),
    .running   (running)
  );

  always #5 clk = ~clk;

  // expected output vector bits: {cmd_init, cmd_step, step_auto, rx_ready, running}
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       b;
    logic [4:0] e;
  } vec_t;

`ifdef CMD_ESC_FILTER_EN
  localparam logic [4:0] ESC_ROW17 = 5'b00010;
`else
  localparam logic [4:0] ESC_ROW17 = 5'b01000;
`endif

  vec_t tbl[22];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic b);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    busy     = b;
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {3'b000, cmd_init, cmd_step, step_auto, rx_ready, running};
  endfunction

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 5'b00010};
    tbl[1]  = '{1'b1, 8'h41, 1'b0, 5'b00010};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 5'b10000};
    tbl[3]  = '{1'b1, 8'h41, 1'b0, 5'b00010};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 5'b00010};
    tbl[5]  = '{1'b1, 8'h31, 1'b1, 5'b00010};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 5'b00000};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 5'b00000};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 5'b01000};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 5'b00010};
    tbl[10] = '{1'b1, 8'h30, 1'b0, 5'b00010};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 5'b00000};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 5'b10000};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 5'b00010};
    tbl[14] = '{1'b1, 8'h1B, 1'b0, 5'b00010};
    tbl[15] = '{1'b1, 8'h5B, 1'b0, 5'b00010};
    tbl[16] = '{1'b1, 8'h31, 1'b0, 5'b00010};
    tbl[17] = '{1'b1, 8'h7E, 1'b0, ESC_ROW17};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 5'b00010};
    tbl[19] = '{1'b1, 8'h30, 1'b0, 5'b00010};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 5'b10000};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 5'b00010};
    #1;
    chk("reset_outputs", outs(), 8'b00010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 22; r++) begin
      drive(tbl[r].v, tbl[r].d, tbl[r].b);
      chk($sformatf("row%0d", r), outs(), {3'b000, tbl[r].e});
    end
    // free-run: auto pulse every 16 cycles, then '1' landing on an expiry cycle
    drive(1'b1, 8'h20, 1'b0);
    chk("run_go", outs(), 8'b00010);
    for (int i = 0; i < 63; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      chk($sformatf("run_i%0d", i), {5'b0, cmd_step, step_auto, running},
          {5'b0, (i % 16 == 15), (i % 16 == 15), 1'b1});
    end
    drive(1'b1, 8'h31, 1'b0);
    chk("stop_on_expiry", {6'b0, cmd_init, cmd_step}, 8'h00);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      chk($sformatf("stopped_i%0d", i), {6'b0, cmd_step, running}, 8'h00);
    end
    // pending '0' meets timer expiry; then ' ' in an expiry cycle
    drive(1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 49; i++) begin
      if (i == 14 || i == 48) drive(1'b1, (i == 14) ? 8'h30 : 8'h20, 1'b0);
      else drive(1'b0, 8'h00, 1'b0);
      chk($sformatf("coin_i%0d", i), {5'b0, cmd_init, cmd_step, step_auto},
          {5'b0, (i == 15), (i == 16 || i == 32), (i == 16 || i == 32)});
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      chk($sformatf("toggled_off_i%0d", i), {6'b0, cmd_step, running}, 8'h00);
    end
    // asynchronous reset with a command pending behind busy
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b1, 8'h30, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    chk("pend_busy", outs(), 8'b00001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 8'b00010);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      chk($sformatf("post_reset_i%0d", i), outs(), 8'b00010);
    end
    drive(1'b1, 8'h31, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("boot_again", {6'b0, cmd_init, cmd_step}, 8'b10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
